apb_master: RTL and testbench

APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers on pclk. It drives the same APB signal set consumed by the team's apb_s responder and returns read data and error status on a one-cycle response strobe. An optional watchdog terminates transfers whose responder never asserts pready.

---
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command port to APB requester with wait-state watchdog
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] WAIT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  accept;
  logic                  expire;

  // A late pready in the expiry cycle wins because expire requires !pready.
  assign expire    = (TIMEOUT > 0) && (state_q == ACCESS) && !pready && (wait_q == LAST_WAIT);
  assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign accept    = cmd_valid && cmd_ready;

  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_d        = '0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = accept ? SETUP : IDLE;
        end else if (expire) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_d = (wait_q != WAIT_MAX) ? wait_q + CW'(1) : wait_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // accept is only possible in IDLE or in a completing ACCESS cycle
    if (accept) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_q        <= wait_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized scoreboard bench for apb_master
module tb_apb_master;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(clk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
    int          gap;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    bit          slverr;
    bit          tmo;
    int          cyc;
  } rsp_t;

  cmd_t stim_q[$];
  cmd_t plan_q[$];
  cmd_t apb_q[$];
  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int waits, bit err, int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.rdata = rdata;
    c.waits = waits; c.err = err; c.gap = gap;
    return c;
  endfunction

  // Responder: each transfer holds off pready for its planned number of wait states.
  cmd_t rcur;
  int   rcnt = 0;
  always @(negedge clk) begin
    if (!presetn || !psel) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (!penable) begin
      if (plan_q.size() == 0) begin
        errors++;
        $display("FAIL responder_setup: unplanned transfer at addr 0x%0h", paddr);
      end else begin
        rcur = plan_q.pop_front();
      end
      rcnt   = rcur.waits;
      pready = 1'b0;
    end else if (rcnt == 0) begin
      pready  = 1'b1;
      prdata  = rcur.wr ? $urandom : rcur.rdata;
      pslverr = rcur.err;
    end else begin
      rcnt--;
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
  end

  // Monitor: APB phase checks and response scoreboard.
  cmd_t acur;
  rsp_t e;
  always @(negedge clk) begin
    if (presetn) begin
      check("penable_without_psel", penable & ~psel, 0);
      if (psel && !penable) begin
        check("cmd_ready_in_setup", cmd_ready, 0);
        if (apb_q.size() == 0) begin
          errors++;
          $display("FAIL apb_setup: unexpected transfer addr 0x%0h", paddr);
        end else begin
          acur = apb_q.pop_front();
          check("setup_paddr", paddr, acur.addr);
          check("setup_pwrite", pwrite, acur.wr);
          check("setup_pwdata", pwdata, acur.wdata);
        end
      end else if (psel && penable) begin
        check("access_paddr_stable", paddr, acur.addr);
        check("access_pwrite_stable", pwrite, acur.wr);
        check("access_pwdata_stable", pwdata, acur.wdata);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid with empty scoreboard at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_slverr", rsp_slverr, e.slverr);
          check("rsp_timeout", rsp_timeout, e.tmo);
          check("rsp_cycle", cyc, e.cyc);
          if (e.tmo) check("psel_after_timeout", {psel, penable}, 0);
        end
      end
    end
  end

  task automatic run_stim();
    cmd_t cur;
    rsp_t x;
    bit   have = 0;
    bit   tmo;
    int   idle = 0;
    int   guard = 0;
    while ((stim_q.size() > 0 || have) && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
      if (!have && stim_q.size() > 0) begin
        if (idle > 0) idle--;
        else begin
          cur  = stim_q.pop_front();
          have = 1;
        end
      end
      cmd_valid = have;
      cmd_write = have ? cur.wr : 1'($urandom);
      cmd_addr  = have ? cur.addr : $urandom;
      cmd_wdata = have ? cur.wdata : $urandom;
      #1;
      if (have && cmd_ready) begin
        tmo      = (cur.waits >= TIMEOUT);
        x.tmo    = tmo;
        x.slverr = tmo | cur.err;
        x.rdata  = (tmo || cur.wr) ? 32'h0 : cur.rdata;
        x.cyc    = cyc + (tmo ? 2 + TIMEOUT : 3 + cur.waits);
        exp_q.push_back(x);
        plan_q.push_back(cur);
        apb_q.push_back(cur);
        have = 0;
        idle = cur.gap;
      end
    end
    if (guard >= 20000) begin
      errors++;
      $display("FAIL driver_budget: commands not accepted within cycle budget");
    end
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("all_responses_seen", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_psel", psel, 0);
    check("reset_penable", penable, 0);
    check("reset_pwrite", pwrite, 0);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_flags", {rsp_slverr, rsp_timeout}, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    presetn = 1'b1;

    stim_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0));
    stim_q.push_back(mk(0, 32'h20, 0, 32'h12345678, 3, 0, 2));
    stim_q.push_back(mk(1, 32'h0, 32'h11111111, 0, 0, 0, 0));
    stim_q.push_back(mk(1, 32'h4, 32'h22222222, 0, 0, 0, 0));
    stim_q.push_back(mk(1, 32'h8, 32'h33333333, 0, 0, 0, 1));
    stim_q.push_back(mk(0, 32'hFF, 0, 32'hCAFEF00D, 0, 1, 0));
    stim_q.push_back(mk(0, 32'h30, 0, 32'hA5A5A5A5, 1, 0, 1));
    stim_q.push_back(mk(1, 32'h40, 32'h0BADC0DE, 0, 1000, 0, 0));
    stim_q.push_back(mk(0, 32'h44, 0, 32'h87654321, 0, 0, 0));
    stim_q.push_back(mk(0, 32'h48, 0, 32'h5EED5EED, TIMEOUT - 1, 0, 0));
    stim_q.push_back(mk(1, 32'h4C, 32'h77777777, 0, TIMEOUT, 0, 0));
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 9);
      int w = (r < 6) ? $urandom_range(0, 2) :
              (r < 8) ? $urandom_range(3, 6) :
              (r == 8) ? TIMEOUT - 1 : TIMEOUT + $urandom_range(0, 3);
      stim_q.push_back(mk(1'($urandom), $urandom, $urandom, $urandom, w,
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 2)));
    end
    run_stim();
    drain();

    stim_q.push_back(mk(0, 32'h50, 0, 32'h99999999, 1000, 0, 0));
    run_stim();
    for (int i = 0; i < 20 && !(psel && penable); i++) @(negedge clk);
    check("reached_access", psel && penable, 1);
    @(negedge clk);
    #2;
    presetn = 1'b0;
    #1;
    check("midreset_psel", psel, 0);
    check("midreset_penable", penable, 0);
    check("midreset_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    plan_q.delete();
    apb_q.delete();
    @(negedge clk);
    #1;
    presetn = 1'b1;
    @(negedge clk);
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("no_rsp_after_reset", rsp_valid, 0);

    stim_q.push_back(mk(0, 32'h60, 0, 32'h13572468, 1, 0, 0));
    run_stim();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
